// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory
// wait freeze with a sticky timeout flag and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RsIF2ID,
    input  logic [4:0]  RtIF2ID,
    input  logic [4:0]  RtID2EX,
    input  logic        MemReadID2EX,
    input  logic        BranchTaken,
    input  logic        MemReq,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        PipeFreeze,
    output logic        MemTimeout,
    output logic [15:0] StallCount
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 16;
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   TIMEOUT_W = CNT_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MEMWAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_inc;
    logic               r_timeout;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_load_use;
    logic               w_mem_block;

    assign w_load_use = MemReadID2EX && (RtID2EX != 5'd0) &&
                        ((RtID2EX == RsIF2ID) || (RtID2EX == RtIF2ID));

    // Once waiting, only MemReady releases the freeze; MemReq is not re-examined.
    assign w_mem_block = (r_state == S_RUN) ? (MemReq && !MemReady) : !MemReady;

    assign w_wait_inc  = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    // Next-state and zero-latency control decode; freeze outranks branch outranks load-use.
    always_comb begin
        w_state_nxt = r_state;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        PipeFreeze  = 1'b0;
        if (w_mem_block) begin
            w_state_nxt = S_MEMWAIT;
            PipeFreeze  = 1'b1;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
        end else begin
            w_state_nxt = S_RUN;
            if (BranchTaken) begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end else if (w_load_use) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter and sticky timeout; the flag sets on the edge the count reaches TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_mem_block) begin
            if (r_state == S_RUN) begin
                r_wait_cnt <= CNT_W'(1);
            end else begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc >= TIMEOUT_W) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign MemTimeout = r_timeout;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RsIF2ID, RtIF2ID, RtID2EX;
    logic        MemReadID2EX, BranchTaken, MemReq, MemReady;
    logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze;
    logic        MemTimeout;
    logic [15:0] StallCount;
    logic [5:0]  w_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit          m_waiting;
    int          m_wcnt;
    bit          m_timeout;
    int          m_stall;

    hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RsIF2ID(RsIF2ID), .RtIF2ID(RtIF2ID), .RtID2EX(RtID2EX),
        .MemReadID2EX(MemReadID2EX), .BranchTaken(BranchTaken),
        .MemReq(MemReq), .MemReady(MemReady),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .PipeFreeze(PipeFreeze),
        .MemTimeout(MemTimeout), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    assign w_ctrl = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze};

    // Expected {PCWrite,IFIDWrite,IDEXBubble,IFIDFlush,IDEXFlush,PipeFreeze}.
    function automatic logic [5:0] exp_ctrl();
        bit lu;
        bit blocked;
        lu = MemReadID2EX && (RtID2EX != 0) && ((RtID2EX == RsIF2ID) || (RtID2EX == RtIF2ID));
        blocked = m_waiting ? !MemReady : (MemReq && !MemReady);
        if (blocked)          return 6'b000001;
        else if (BranchTaken) return 6'b110110;
        else if (lu)          return 6'b001000;
        else                  return 6'b110000;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_wcnt = 0; m_timeout = 0; m_stall = 0;
    endtask

    // Drive inputs, then wait to the falling edge where outputs are sampled.
    task automatic set_in(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic mq, input logic mrdy);
        MemReadID2EX = mr; RtID2EX = rt_ex; RsIF2ID = rs; RtIF2ID = rt;
        BranchTaken = br; MemReq = mq; MemReady = mrdy;
        @(negedge clk);
    endtask

    // Advance one rising edge and update the model from the pre-edge view.
    task automatic tick();
        logic [5:0] c;
        c = exp_ctrl();
        @(posedge clk);
        if (!c[5] && m_stall < 16'hFFFF) m_stall++;
        if (!m_waiting) begin
            if (MemReq && !MemReady) begin
                m_waiting = 1; m_wcnt = 1;
            end
        end else if (MemReady) begin
            m_waiting = 0;
        end else begin
            if (m_wcnt < 255) m_wcnt++;
            if (m_wcnt >= TO) m_timeout = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        MemReadID2EX = 0; RtID2EX = 0; RsIF2ID = 0; RtIF2ID = 0;
        BranchTaken = 0; MemReq = 0; MemReady = 0;
        model_reset();
        #12;
        n_checks++;
        if (StallCount !== 16'd0) begin
            n_fail++; $display("FAIL reset_stallcount: got %h want 0000", StallCount);
        end
        n_checks++;
        if (MemTimeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_timeout: got %b want 0", MemTimeout);
        end
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 110000", w_ctrl);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 5'd5, 5'd5, 5'd9, 0, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b001000) begin
            n_fail++; $display("FAIL load_use_ctrl: got %b want 001000", w_ctrl);
        end
        n_checks++;
        if (StallCount !== 16'd0) begin
            n_fail++; $display("FAIL load_use_cnt0: got %0d want 0", StallCount);
        end
        tick();
        set_in(0, 5'd5, 5'd5, 5'd9, 0, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL load_use_release: got %b want 110000", w_ctrl);
        end
        n_checks++;
        if (StallCount !== 16'd1) begin
            n_fail++; $display("FAIL load_use_cnt1: got %0d want 1", StallCount);
        end
        tick();
        set_in(1, 5'd7, 5'd3, 5'd7, 0, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b001000) begin
            n_fail++; $display("FAIL load_use_rt: got %b want 001000", w_ctrl);
        end
        tick();
    endtask

    task automatic test_no_false_hazard();
        set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL no_hazard_r0: got %b want 110000", w_ctrl);
        end
        tick();
        set_in(0, 5'd6, 5'd6, 5'd6, 0, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL no_hazard_noload: got %b want 110000", w_ctrl);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        set_in(1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b110110) begin
            n_fail++; $display("FAIL branch_over_loaduse: got %b want 110110", w_ctrl);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, i == 1, 1, 0);
            n_checks++;
            if (w_ctrl !== 6'b000001) begin
                n_fail++; $display("FAIL mem_wait_freeze%0d: got %b want 000001", i, w_ctrl);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL mem_wait_release: got %b want 110000", w_ctrl);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (StallCount !== 16'd3) begin
            n_fail++; $display("FAIL mem_wait_count: got %0d want 3", StallCount);
        end
        n_checks++;
        if (MemTimeout !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_no_timeout: got %b want 0", MemTimeout);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            n_checks++;
            if (MemTimeout !== (i > 4)) begin
                n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", i, MemTimeout, i > 4);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL timeout_release: got %b want 110000", w_ctrl);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (MemTimeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: got %b want 1", MemTimeout);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1));
            e = exp_ctrl();
            n_checks++;
            if (w_ctrl !== e) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, w_ctrl, e);
            end
            n_checks++;
            if (StallCount !== 16'(m_stall) || MemTimeout !== m_timeout) begin
                n_fail++; $display("FAIL rand_regs[%0d]: got cnt=%0d to=%b want cnt=%0d to=%b",
                                   i, StallCount, MemTimeout, m_stall, m_timeout);
            end
            if (w_ctrl[5] === 1'b0 && w_ctrl[0] === 1'b0 && w_ctrl[2] === 1'b1) begin
                n_fail++; $display("FAIL rand_flush_stall[%0d]: got %b", i, w_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_saturation_reset();
        MemReadID2EX = 0; BranchTaken = 0; MemReq = 1; MemReady = 0;
        while (m_stall < 16'hFFFE) tick();
        set_in(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (StallCount !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_preload: got %h want FFFE", StallCount);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        n_checks++;
        if (StallCount !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want FFFF", StallCount);
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (StallCount !== 16'd0 || MemTimeout !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_regs: got cnt=%h to=%b want 0000 0", StallCount, MemTimeout);
        end
        MemReq = 0;
        #1;
        n_checks++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++; $display("FAIL async_reset_state: got %b want 110000", w_ctrl);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (w_ctrl !== 6'b110000 || StallCount !== 16'd0) begin
            n_fail++; $display("FAIL post_reset_run: got %b cnt=%0d want 110000 cnt=0", w_ctrl, StallCount);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_random();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
